// File: rtl/maze_pkg.sv
// Shared maze definitions: default size, controller state encoding, cell encoding.
package maze_pkg;

  localparam int unsigned MAZE_WIDTH_DEFAULT = 6;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DUMP  = 2'd2
  } maze_state_e;

  localparam logic WALL     = 1'b1;
  localparam logic CORRIDOR = 1'b0;

endpackage

// File: rtl/maze_memory_if.sv
// Solver-side maze access bus: the solver drives row/col/oe/we and the memory returns maze_in.
interface maze_memory_if #(
  parameter int unsigned maze_width = maze_pkg::MAZE_WIDTH_DEFAULT
);

  logic [maze_width-1:0] row;
  logic [maze_width-1:0] col;
  logic                  maze_oe;
  logic                  maze_we;
  logic                  maze_in;

  modport master (
    output row, col, maze_oe, maze_we,
    input  maze_in
  );

  modport slave (
    input  row, col, maze_oe, maze_we,
    output maze_in
  );

endinterface

// File: rtl/maze_row_stream.sv
// Row counter with valid/ready sequencing; flags the handshake on the final row.
module maze_row_stream #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         valid,
  input  logic         ready,
  output logic [W-1:0] cnt,
  output logic         fire_c,
  output logic         done_c
);

  assign fire_c = valid & ready;
  assign done_c = fire_c & (cnt == {W{1'b1}});

  // Row index advances on every handshake; the final handshake wraps it back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (fire_c) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/maze_memory.sv
// Maze bitmap store: row-streamed wall load, solver read/mark service, row-streamed path dump.
module maze_memory
  import maze_pkg::*;
#(
  parameter  int unsigned maze_width = MAZE_WIDTH_DEFAULT,
  localparam int unsigned N          = 2 ** maze_width,
  localparam int unsigned CW         = 2 * maze_width + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  maze_memory_if.slave  bus,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [N-1:0]  load_data,
  output logic          load_ready,
  input  logic          dump_req,
  output logic          dump_valid,
  output logic [N-1:0]  dump_data,
  input  logic          dump_ready,
  output logic          maze_loaded,
  output logic [CW-1:0] visited_count,
  output logic          err_wall_write
);

  maze_state_e state_q, state_d;

  logic [N-1:0] wall_q    [N];
  logic [N-1:0] visited_q [N];

  logic [maze_width-1:0] load_cnt, dump_cnt;
  logic load_fire_c, load_done_c, load_clr_c;
  logic dump_fire_c, dump_done_c, dump_clr_c;
  logic serve_c, mark_c, cell_wall_c, cell_visited_c;

  logic          load_ready_q, maze_loaded_q, dump_valid_q;
  logic          maze_in_q, err_q;
  logic [N-1:0]  dump_data_q;
  logic [CW-1:0] count_q;

  maze_row_stream #(.W(maze_width)) u_load_stream (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (load_clr_c),
    .valid  (load_valid),
    .ready  (load_ready_q),
    .cnt    (load_cnt),
    .fire_c (load_fire_c),
    .done_c (load_done_c)
  );

  maze_row_stream #(.W(maze_width)) u_dump_stream (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (dump_clr_c),
    .valid  (dump_valid_q),
    .ready  (dump_ready),
    .cnt    (dump_cnt),
    .fire_c (dump_fire_c),
    .done_c (dump_done_c)
  );

  assign serve_c        = (state_q == SERVE);
  assign mark_c         = serve_c & ~load_start & bus.maze_we;
  assign cell_wall_c    = (wall_q[bus.row][bus.col] == WALL);
  assign cell_visited_c = visited_q[bus.row][bus.col];

  // Controller state register plus registered state-derived status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      load_ready_q  <= 1'b1;
      maze_loaded_q <= 1'b0;
      dump_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_ready_q  <= (state_d == LOAD);
      maze_loaded_q <= (state_d != LOAD);
      dump_valid_q  <= (state_d == DUMP);
    end
  end

  // Next-state logic; a reload request outranks a dump request.
  always_comb begin
    state_d    = state_q;
    load_clr_c = 1'b0;
    dump_clr_c = 1'b0;
    case (state_q)
      LOAD: begin
        if (load_done_c) state_d = SERVE;
      end
      SERVE: begin
        if (load_start) begin
          state_d    = LOAD;
          load_clr_c = 1'b1;
        end else if (dump_req) begin
          state_d    = DUMP;
          dump_clr_c = 1'b1;
        end
      end
      DUMP: begin
        if (dump_done_c) state_d = SERVE;
      end
      default: state_d = LOAD;
    endcase
  end

  // Wall bitmap: one full row written per load handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) wall_q[i] <= '0;
    end else if (load_fire_c) begin
      wall_q[load_cnt] <= load_data;
    end
  end

  // Path marks, distinct-cell count and sticky wall-write error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) visited_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (serve_c && load_start) begin
      for (int unsigned i = 0; i < N; i++) visited_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (mark_c) begin
      if (cell_wall_c) begin
        err_q <= 1'b1;
      end else begin
        visited_q[bus.row][bus.col] <= 1'b1;
        if (!cell_visited_c) count_q <= count_q + CW'(1);
      end
    end
  end

  // Read port: maze_in holds the last read wall bit until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maze_in_q <= WALL;
    end else if (serve_c && bus.maze_oe) begin
      maze_in_q <= wall_q[bus.row][bus.col];
    end
  end

  // Dump word: row 0 on entry, next row after each accepted word, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_data_q <= '0;
    end else if (dump_clr_c) begin
      dump_data_q <= visited_q[0];
    end else if (dump_fire_c) begin
      if (dump_done_c) dump_data_q <= '0;
      else             dump_data_q <= visited_q[dump_cnt + maze_width'(1)];
    end
  end

  assign bus.maze_in    = maze_in_q;
  assign load_ready     = load_ready_q;
  assign maze_loaded    = maze_loaded_q;
  assign dump_valid     = dump_valid_q;
  assign dump_data      = dump_data_q;
  assign visited_count  = count_q;
  assign err_wall_write = err_q;

endmodule
